// File: rtl/cnt_cmd_seq.sv
// cnt_cmd_seq: command FIFO feeding a two-state sequencer that issues count enables to a downstream counter.
module cnt_cmd_seq #(
  parameter int DEPTH = 4,
  parameter int LEN_W = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_up,
  input  logic [LEN_W-1:0]             cmd_len,
  input  logic                         hold,
  input  logic                         abort,
  output logic                         ce,
  output logic                         up,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_cnt
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [LEN_W:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic ce_q, ce_d, up_q, up_d, busy_q, busy_d, done_q, done_d;
  logic push, pop;
  logic [LEN_W:0] head;
  assign head = mem[rd_ptr_q];
  assign cmd_ready = (cnt_q != CW'(DEPTH)) && !abort;
  assign push = cmd_valid && cmd_ready;
  assign pop = (state_q == IDLE) && (cnt_q != '0) && !abort;
  always_comb begin
    state_d = state_q;
    rem_d = rem_q;
    ce_d = 1'b0;
    done_d = 1'b0;
    up_d = up_q;
    busy_d = busy_q;
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    if (abort) begin
      state_d = IDLE;
      busy_d = 1'b0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d = '0;
    end else if (pop) begin
      up_d = head[LEN_W];
      rem_d = head[LEN_W-1:0];
      busy_d = head[LEN_W-1:0] != '0;
      state_d = (head[LEN_W-1:0] != '0) ? RUN : IDLE;
      done_d = head[LEN_W-1:0] == '0;
    end else if (state_q == RUN && !hold && rem_q != '0) begin
      ce_d = 1'b1;
      rem_d = rem_q - LEN_W'(1);
      // last enable: finish in the same cycle it is issued
      if (rem_q == LEN_W'(1)) begin
        done_d = 1'b1;
        busy_d = 1'b0;
        state_d = IDLE;
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q <= '0;
      rem_q <= '0;
      ce_q <= 1'b0;
      up_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      ce_q <= ce_d;
      up_q <= up_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {cmd_up, cmd_len};
  end
  assign ce = ce_q;
  assign up = up_q;
  assign busy = busy_q;
  assign done = done_q;
  assign fifo_cnt = cnt_q;
endmodule

// File: tb/tb_cnt_cmd_seq.sv
// tb_cnt_cmd_seq: directed self-checking bench for cnt_cmd_seq.
module tb_cnt_cmd_seq;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cmd_valid = 1'b0, cmd_up = 1'b0, hold = 1'b0, abort = 1'b0;
  logic [3:0] cmd_len = '0;
  logic cmd_ready, ce, up, busy, done;
  logic [2:0] fifo_cnt;
  int errs = 0, checks = 0, ce_cnt;

  cnt_cmd_seq dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_up(cmd_up), .cmd_len(cmd_len), .hold(hold), .abort(abort),
    .ce(ce), .up(up), .busy(busy), .done(done), .fifo_cnt(fifo_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic u, input logic [3:0] l);
    cmd_valid = 1'b1;
    cmd_up = u;
    cmd_len = l;
  endtask

  initial begin
    #2;
    chk("rst_ce", ce, 0);
    chk("rst_up", up, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", fifo_cnt, 0);
    chk("rst_ready", cmd_ready, 1);
    #10 rst = 1'b1;
    tick();
    // up=1 len=3, no hold
    offer(1, 3);
    tick();
    cmd_valid = 1'b0;
    chk("l3_cnt_E", fifo_cnt, 1);
    chk("l3_busy_E", busy, 0);
    tick();
    chk("l3_busy_E1", busy, 1);
    chk("l3_ce_E1", ce, 0);
    chk("l3_up_E1", up, 1);
    chk("l3_cnt_E1", fifo_cnt, 0);
    tick();
    chk("l3_ce_E2", ce, 1);
    chk("l3_busy_E2", busy, 1);
    chk("l3_done_E2", done, 0);
    tick();
    chk("l3_ce_E3", ce, 1);
    chk("l3_busy_E3", busy, 1);
    chk("l3_done_E3", done, 0);
    tick();
    chk("l3_ce_E4", ce, 1);
    chk("l3_done_E4", done, 1);
    chk("l3_up_E4", up, 1);
    tick();
    chk("l3_ce_E5", ce, 0);
    chk("l3_done_E5", done, 0);
    chk("l3_busy_E5", busy, 0);
    // len=0
    offer(0, 0);
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("l0_done_E1", done, 1);
    chk("l0_busy_E1", busy, 0);
    chk("l0_ce_E1", ce, 0);
    chk("l0_up_E1", up, 0);
    tick();
    chk("l0_done_E2", done, 0);
    chk("l0_ce_E2", ce, 0);
    // len=4 down with hold pattern 1,0,1,1,0 then 0
    offer(0, 4);
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("l4_busy", busy, 1);
    begin
      logic [6:0] hp, cep, dnp;
      hp = 7'b0001101;
      cep = 7'b1110010;
      dnp = 7'b1000000;
      ce_cnt = 0;
      for (int i = 0; i < 7; i++) begin
        hold = hp[i];
        tick();
        chk($sformatf("l4_ce_%0d", i), ce, cep[i]);
        chk($sformatf("l4_done_%0d", i), done, dnp[i]);
        if (ce) ce_cnt++;
      end
      hold = 1'b0;
    end
    tick();
    chk("l4_ce_after", ce, 0);
    chk("l4_total", ce_cnt, 4);
    chk("l4_up", up, 0);
    // fill under hold with 6 back-to-back commands
    hold = 1'b1;
    offer(1, 1);
    begin
      logic [2:0] ec [6] = '{1, 1, 2, 3, 4, 4};
      logic [5:0] er;
      er = 6'b001111;
      for (int i = 0; i < 6; i++) begin
        tick();
        chk($sformatf("fill_cnt_%0d", i), fifo_cnt, ec[i]);
        chk($sformatf("fill_rdy_%0d", i), cmd_ready, er[i]);
        chk($sformatf("fill_ce_%0d", i), ce, 0);
      end
    end
    chk("fill_busy", busy, 1);
    hold = 1'b0;
    tick();
    chk("drain_ce7", ce, 1);
    chk("drain_cnt7", fifo_cnt, 4);
    tick();
    chk("drain_ce8", ce, 0);
    chk("drain_cnt8", fifo_cnt, 3);
    chk("drain_rdy8", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    chk("drain_ce9", ce, 1);
    chk("drain_cnt9", fifo_cnt, 4);
    // abort with a valid command offered: nothing accepted, queue flushed
    offer(1, 2);
    abort = 1'b1;
    #1;
    chk("abort_rdy", cmd_ready, 0);
    tick();
    abort = 1'b0;
    cmd_valid = 1'b0;
    chk("abort_cnt", fifo_cnt, 0);
    chk("abort_busy", busy, 0);
    tick();
    chk("abort_idle_cnt", fifo_cnt, 0);
    chk("abort_idle_ce", ce, 0);
    // len=5 running, 3 queued, abort after second ce
    hold = 1'b1;
    offer(1, 5);
    tick();
    tick();
    tick();
    tick();
    cmd_valid = 1'b0;
    chk("ab5_cnt", fifo_cnt, 3);
    hold = 1'b0;
    tick();
    chk("ab5_ce1", ce, 1);
    tick();
    chk("ab5_ce2", ce, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab5_ce", ce, 0);
    chk("ab5_busy", busy, 0);
    chk("ab5_cnt0", fifo_cnt, 0);
    chk("ab5_done", done, 0);
    chk("ab5_up", up, 1);
    ce_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ce || done) ce_cnt++;
    end
    chk("ab5_quiet", ce_cnt, 0);
    // reset mid-RUN with 2 queued
    hold = 1'b1;
    offer(1, 6);
    tick();
    tick();
    tick();
    cmd_valid = 1'b0;
    chk("rr_cnt", fifo_cnt, 2);
    hold = 1'b0;
    tick();
    chk("rr_ce", ce, 1);
    #2 rst = 1'b0;
    #1;
    chk("rr_ce0", ce, 0);
    chk("rr_busy0", busy, 0);
    chk("rr_cnt0", fifo_cnt, 0);
    chk("rr_rdy", cmd_ready, 1);
    chk("rr_up0", up, 0);
    #2 rst = 1'b1;
    ce_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ce || busy) ce_cnt++;
    end
    chk("rr_quiet", ce_cnt, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
